// File: rtl/multi_channel_event_counter_pkg.sv
// Shared definitions for the multi-channel event counter.
//   - default parameter values (channel count, counter width, sync depth)
//   - ovf_mode_e : overflow behaviour selector (wrap / saturate)
//   - width helpers used to size the read-select buses
package mcec_pkg;

  localparam int DEF_NUM_CH      = 8;
  localparam int DEF_CNT_W       = 16;
  localparam int DEF_SYNC_STAGES = 2;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } ovf_mode_e;

  // Width of a select bus addressing n items; never narrower than 1 bit.
  function automatic int sel_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Number of bytes in a counter of width cnt_w.
  function automatic int cnt_bytes(input int cnt_w);
    return cnt_w / 8;
  endfunction

endpackage

// File: rtl/multi_channel_event_counter_if.sv
// Control/readback bundle of the multi-channel event counter.
//   master : drives ena, ch_in, ch_mask, mode_sat, clr, snap, rd_sel, rd_byte;
//            receives rd_data, ovf, snap_valid
//   slave  : the counter block itself (directions mirrored)
interface multi_channel_event_counter_if
  import mcec_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CNT_W  = DEF_CNT_W
) ();

  localparam int SEL_W  = sel_width(NUM_CH);
  localparam int BYTE_W = sel_width(cnt_bytes(CNT_W));

  logic              ena;
  logic [NUM_CH-1:0] ch_in;
  logic [NUM_CH-1:0] ch_mask;
  logic              mode_sat;
  logic              clr;
  logic              snap;
  logic [SEL_W-1:0]  rd_sel;
  logic [BYTE_W-1:0] rd_byte;
  logic [7:0]        rd_data;
  logic [NUM_CH-1:0] ovf;
  logic              snap_valid;

  modport master (
    output ena, ch_in, ch_mask, mode_sat, clr, snap, rd_sel, rd_byte,
    input  rd_data, ovf, snap_valid
  );

  modport slave (
    input  ena, ch_in, ch_mask, mode_sat, clr, snap, rd_sel, rd_byte,
    output rd_data, ovf, snap_valid
  );

endinterface

// File: rtl/multi_channel_event_counter_channel.sv
// One counting channel: input synchroniser, rising-edge detector, event
// counter with wrap/saturate overflow, sticky overflow flag and shadow copy.
//   clk, rst     : clock, asynchronous active-high reset
//   ch_i         : asynchronous event input
//   ena_i/mask_i : global enable / this channel's enable
//   mode_sat_i   : 1 = saturate, 0 = wrap on overflow
//   clr_i        : synchronous clear of counter and overflow flag
//   snap_i       : copy counter into shadow (pre-update value)
//   shadow_o     : shadow register
//   ovf_o        : sticky overflow flag
module mcec_channel
  import mcec_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ch_i,
  input  logic             ena_i,
  input  logic             mask_i,
  input  logic             mode_sat_i,
  input  logic             clr_i,
  input  logic             snap_i,
  output logic [CNT_W-1:0] shadow_o,
  output logic             ovf_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   prev_q;
  logic                   armed_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;
  logic [CNT_W-1:0]       shadow_q;

  logic      sync_last;
  logic      sync_real;
  logic      rise;
  logic      inc;
  ovf_mode_e mode;

  assign sync_last = sync_q[SYNC_STAGES-1];
  // fill_q marks when the synchroniser output carries a genuine sample
  // rather than the zeros left behind by reset.
  assign sync_real = fill_q[SYNC_STAGES-1];

  // armed_q only rises after a real low has been seen, so an input that is
  // already high when reset releases cannot produce a count.
  assign rise = sync_last & ~prev_q & armed_q;
  assign inc  = rise & ena_i & mask_i;

  always_comb begin
    mode  = ovf_mode_e'(mode_sat_i);
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr_i) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (inc) begin
      if (&cnt_q) begin
        ovf_d = 1'b1;
        cnt_d = (mode == MODE_SAT) ? cnt_q : '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      fill_q   <= '0;
      prev_q   <= 1'b0;
      armed_q  <= 1'b0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      shadow_q <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], ch_i};
      fill_q  <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      prev_q  <= sync_last;
      armed_q <= armed_q | (sync_real & ~sync_last);
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      if (snap_i) begin
        shadow_q <= cnt_q;
      end
    end
  end

  assign shadow_o = shadow_q;
  assign ovf_o    = ovf_q;

endmodule

// File: rtl/multi_channel_event_counter.sv
// Multi-channel event counter top: NUM_CH independent channels plus the
// shadow read mux and the snapshot-valid flag.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : control/readback bundle (slave side)
module multi_channel_event_counter
  import mcec_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                          clk,
  input  logic                          rst,
  multi_channel_event_counter_if.slave  bus
);

  localparam int SEL_W  = sel_width(NUM_CH);
  localparam int NBYTES = cnt_bytes(CNT_W);
  localparam int BYTE_W = sel_width(NBYTES);

  logic [CNT_W-1:0]  shadow [NUM_CH];
  logic [NUM_CH-1:0] ovf;
  logic              snap_valid_q;
  logic [7:0]        rd_data_d;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      mcec_channel #(
        .CNT_W      (CNT_W),
        .SYNC_STAGES(SYNC_STAGES)
      ) u_ch (
        .clk       (clk),
        .rst       (rst),
        .ch_i      (bus.ch_in[gi]),
        .ena_i     (bus.ena),
        .mask_i    (bus.ch_mask[gi]),
        .mode_sat_i(bus.mode_sat),
        .clr_i     (bus.clr),
        .snap_i    (bus.snap),
        .shadow_o  (shadow[gi]),
        .ovf_o     (ovf[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_valid_q <= 1'b0;
    end else if (bus.snap) begin
      snap_valid_q <= 1'b1;
    end
  end

  // Full decode over legal (channel, byte) pairs; any out-of-range select
  // matches nothing and reads 0x00.
  always_comb begin
    rd_data_d = 8'h00;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (bus.rd_sel == SEL_W'(c) && bus.rd_byte == BYTE_W'(b)) begin
          rd_data_d = shadow[c][8*b +: 8];
        end
      end
    end
  end

  assign bus.rd_data    = rd_data_d;
  assign bus.ovf        = ovf;
  assign bus.snap_valid = snap_valid_q;

endmodule

// File: tb/tb_multi_channel_event_counter.sv
module tb_multi_channel_event_counter;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  logic [7:0] d;

  multi_channel_event_counter_if #(.NUM_CH(8), .CNT_W(16)) if16 ();
  multi_channel_event_counter_if #(.NUM_CH(3), .CNT_W(8))  if8 ();

  multi_channel_event_counter #(.NUM_CH(8), .CNT_W(16), .SYNC_STAGES(2)) dut16 (
    .clk(clk), .rst(rst), .bus(if16)
  );
  multi_channel_event_counter #(.NUM_CH(3), .CNT_W(8), .SYNC_STAGES(2)) dut8 (
    .clk(clk), .rst(rst), .bus(if8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse16(input logic [7:0] v, input int n);
    repeat (n) begin
      if16.ch_in = v;
      step();
      if16.ch_in = 8'h00;
      step();
    end
  endtask

  task automatic pulse8(input logic [2:0] v, input int n);
    repeat (n) begin
      if8.ch_in = v;
      step();
      if8.ch_in = 3'b000;
      step();
    end
  endtask

  task automatic snap16();
    step(3);
    if16.snap = 1'b1;
    step();
    if16.snap = 1'b0;
  endtask

  task automatic snap8();
    step(3);
    if8.snap = 1'b1;
    step();
    if8.snap = 1'b0;
  endtask

  task automatic rd16(input int sel, input int byt, output logic [7:0] v);
    if16.rd_sel  = 3'(sel);
    if16.rd_byte = 1'(byt);
    #1;
    v = if16.rd_data;
  endtask

  task automatic rd8(input int sel, input int byt, output logic [7:0] v);
    if8.rd_sel  = 2'(sel);
    if8.rd_byte = 1'(byt);
    #1;
    v = if8.rd_data;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(2);
    rd16(0, 0, d);
    n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL reset_rd16: got %h want 00", d); end
    rd8(0, 0, d);
    n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL reset_rd8: got %h want 00", d); end
    n_cmp++; if (if16.ovf !== 8'h00) begin n_bad++; $display("FAIL reset_ovf16: got %h want 00", if16.ovf); end
    n_cmp++; if (if8.ovf !== 3'b000) begin n_bad++; $display("FAIL reset_ovf8: got %b want 000", if8.ovf); end
    n_cmp++; if (if16.snap_valid !== 1'b0) begin n_bad++; $display("FAIL reset_sv16: got %b want 0", if16.snap_valid); end
    n_cmp++; if (if8.snap_valid !== 1'b0) begin n_bad++; $display("FAIL reset_sv8: got %b want 0", if8.snap_valid); end
    rst = 1'b0;
    step(5);
    $display("test_reset done");
  endtask

  task automatic test_single_pulse();
    if16.ena = 1'b1;
    if16.ch_mask = 8'hFF;
    if16.ch_in = 8'h01;
    step();               // edge N samples the high level
    step();               // N+1
    if16.snap = 1'b1;
    step();               // N+2: counter becomes 1, shadow takes old 0
    rd16(0, 0, d);
    n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL latency_pre: got %h want 00", d); end
    step();               // N+3: shadow takes 1
    if16.snap = 1'b0;
    rd16(0, 0, d);
    n_cmp++; if (d !== 8'h01) begin n_bad++; $display("FAIL latency_post: got %h want 01", d); end
    step();               // fifth high sample
    if16.ch_in = 8'h00;
    snap16();
    n_cmp++; if (if16.snap_valid !== 1'b1) begin n_bad++; $display("FAIL single_sv: got %b want 1", if16.snap_valid); end
    for (int c = 0; c < 8; c++) begin
      rd16(c, 0, d);
      n_cmp++;
      if (d !== ((c == 0) ? 8'h01 : 8'h00)) begin
        n_bad++; $display("FAIL single_ch%0d: got %h want %h", c, d, (c == 0) ? 8'h01 : 8'h00);
      end
    end
    rd16(0, 1, d);
    n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL single_hi: got %h want 00", d); end
    $display("test_single_pulse done");
  endtask

  task automatic test_mask_ena();
    if16.clr = 1'b1;
    step();
    if16.clr = 1'b0;
    if16.ch_mask = 8'hFB;
    pulse16(8'hFF, 10);
    snap16();
    for (int c = 0; c < 8; c++) begin
      rd16(c, 0, d);
      n_cmp++;
      if (d !== ((c == 2) ? 8'h00 : 8'h0A)) begin
        n_bad++; $display("FAIL mask_ch%0d: got %h want %h", c, d, (c == 2) ? 8'h00 : 8'h0A);
      end
    end
    if16.ena = 1'b0;
    pulse16(8'hFF, 3);
    step(3);
    if16.ena = 1'b1;
    step(3);
    snap16();
    for (int c = 0; c < 8; c++) begin
      rd16(c, 0, d);
      n_cmp++;
      if (d !== ((c == 2) ? 8'h00 : 8'h0A)) begin
        n_bad++; $display("FAIL ena_off_ch%0d: got %h want %h", c, d, (c == 2) ? 8'h00 : 8'h0A);
      end
    end
    $display("test_mask_ena done");
  endtask

  task automatic test_clr_snap_edge();
    // ch1 holds 10; its edge, clr and snap all land on the same edge
    if16.ch_in = 8'h02;
    step();
    step();
    if16.clr  = 1'b1;
    if16.snap = 1'b1;
    step();
    if16.clr  = 1'b0;
    if16.snap = 1'b0;
    if16.ch_in = 8'h00;
    rd16(1, 0, d);
    n_cmp++; if (d !== 8'h0A) begin n_bad++; $display("FAIL cse_shadow: got %h want 0a", d); end
    n_cmp++; if (if16.snap_valid !== 1'b1) begin n_bad++; $display("FAIL cse_sv: got %b want 1", if16.snap_valid); end
    n_cmp++; if (if16.ovf !== 8'h00) begin n_bad++; $display("FAIL cse_ovf: got %h want 00", if16.ovf); end
    snap16();
    rd16(1, 0, d);
    n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL cse_cnt1: got %h want 00", d); end
    rd16(0, 0, d);
    n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL cse_cnt0: got %h want 00", d); end
    $display("test_clr_snap_edge done");
  endtask

  task automatic test_byte_read();
    if16.ch_mask = 8'hFF;
    pulse16(8'h08, 4660);   // 0x1234 events on ch3
    snap16();
    rd16(3, 1, d);
    n_cmp++; if (d !== 8'h12) begin n_bad++; $display("FAIL byte_hi: got %h want 12", d); end
    rd16(3, 0, d);
    n_cmp++; if (d !== 8'h34) begin n_bad++; $display("FAIL byte_lo: got %h want 34", d); end
    rd16(2, 0, d);
    n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL byte_other: got %h want 00", d); end
    $display("test_byte_read done");
  endtask

  task automatic test_wrap_sat();
    if8.ena = 1'b1;
    if8.ch_mask = 3'b111;
    if8.mode_sat = 1'b0;
    pulse8(3'b001, 257);
    snap8();
    rd8(0, 0, d);
    n_cmp++; if (d !== 8'h01) begin n_bad++; $display("FAIL wrap_cnt: got %h want 01", d); end
    n_cmp++; if (if8.ovf !== 3'b001) begin n_bad++; $display("FAIL wrap_ovf: got %b want 001", if8.ovf); end
    if8.mode_sat = 1'b1;
    if8.clr = 1'b1;
    step();
    if8.clr = 1'b0;
    pulse8(3'b001, 300);
    snap8();
    rd8(0, 0, d);
    n_cmp++; if (d !== 8'hFF) begin n_bad++; $display("FAIL sat_cnt: got %h want ff", d); end
    n_cmp++; if (if8.ovf !== 3'b001) begin n_bad++; $display("FAIL sat_ovf: got %b want 001", if8.ovf); end
    rd8(3, 0, d);
    n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL sel_oor: got %h want 00", d); end
    rd8(0, 1, d);
    n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL byte_oor: got %h want 00", d); end
    if8.clr = 1'b1;
    step();
    if8.clr = 1'b0;
    n_cmp++; if (if8.ovf !== 3'b000) begin n_bad++; $display("FAIL clr_ovf: got %b want 000", if8.ovf); end
    rd8(0, 0, d);
    n_cmp++; if (d !== 8'hFF) begin n_bad++; $display("FAIL clr_keeps_shadow: got %h want ff", d); end
    n_cmp++; if (if8.snap_valid !== 1'b1) begin n_bad++; $display("FAIL clr_keeps_sv: got %b want 1", if8.snap_valid); end
    snap8();
    rd8(0, 0, d);
    n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL clr_cnt: got %h want 00", d); end
    if8.mode_sat = 1'b0;
    pulse8(3'b010, 256);
    step(3);
    n_cmp++; if (if8.ovf !== 3'b010) begin n_bad++; $display("FAIL wrap256_ovf: got %b want 010", if8.ovf); end
    $display("test_wrap_sat done");
  endtask

  task automatic test_async_reset();
    if16.ch_in = 8'hFF;
    if8.ch_in  = 3'b111;
    step(2);
    #2;
    rst = 1'b1;           // between edges
    #1;
    rd16(3, 1, d);
    n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL arst_rd16: got %h want 00", d); end
    n_cmp++; if (if16.snap_valid !== 1'b0) begin n_bad++; $display("FAIL arst_sv16: got %b want 0", if16.snap_valid); end
    n_cmp++; if (if8.ovf !== 3'b000) begin n_bad++; $display("FAIL arst_ovf8: got %b want 000", if8.ovf); end
    n_cmp++; if (if8.snap_valid !== 1'b0) begin n_bad++; $display("FAIL arst_sv8: got %b want 0", if8.snap_valid); end
    step(2);
    rst = 1'b0;
    step(8);
    n_cmp++; if (if16.snap_valid !== 1'b0) begin n_bad++; $display("FAIL post_rst_sv: got %b want 0", if16.snap_valid); end
    snap16();
    snap8();
    rd16(0, 0, d);
    n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL held_high16: got %h want 00", d); end
    rd8(0, 0, d);
    n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL held_high8: got %h want 00", d); end
    if16.ch_in = 8'h00;
    if8.ch_in  = 3'b000;
    step(3);
    if16.ch_in = 8'hFF;
    if8.ch_in  = 3'b111;
    step();
    if16.ch_in = 8'h00;
    if8.ch_in  = 3'b000;
    snap16();
    snap8();
    rd16(0, 0, d);
    n_cmp++; if (d !== 8'h01) begin n_bad++; $display("FAIL fresh_edge16_ch0: got %h want 01", d); end
    rd16(7, 0, d);
    n_cmp++; if (d !== 8'h01) begin n_bad++; $display("FAIL fresh_edge16_ch7: got %h want 01", d); end
    rd8(2, 0, d);
    n_cmp++; if (d !== 8'h01) begin n_bad++; $display("FAIL fresh_edge8_ch2: got %h want 01", d); end
    $display("test_async_reset done");
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    if16.ena = 1'b0; if16.ch_in = '0; if16.ch_mask = '0; if16.mode_sat = 1'b0;
    if16.clr = 1'b0; if16.snap = 1'b0; if16.rd_sel = '0; if16.rd_byte = '0;
    if8.ena = 1'b0;  if8.ch_in = '0;  if8.ch_mask = '0;  if8.mode_sat = 1'b0;
    if8.clr = 1'b0;  if8.snap = 1'b0;  if8.rd_sel = '0;  if8.rd_byte = '0;
    test_reset();
    test_single_pulse();
    test_mask_ena();
    test_clr_snap_edge();
    test_byte_read();
    test_wrap_sat();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
